dual_config_csr_responder: RTL and testbench

//   Responder side of the StateMachine CSR handshake (start_rdsr/start_rdcr/start_wrcr -> rd_data_csr/done_csr).

---
 rtl/dual_config_csr_responder_pkg.sv | 34 +++
 rtl/dual_config_csr_responder_read_port.sv | 48 ++++
 rtl/dual_config_csr_responder.sv | 198 +++++++++++++++++++
 tb/tb_dual_config_csr_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_config_csr_responder_pkg.sv
// csr_pkg: definitions shared by the dual-configuration CSR responder.
//   - csr_state_t : responder FSM states
//   - DEF_*_ADDR  : default register offsets inside the MAX10 dual-config IP
//   - CMD_*       : command bytes that StateMachine uses for the three requests
//   - cfg_word()  : builds the config-select write word from the request payload
package csr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        POLL_ISSUE,
        POLL_WAIT,
        WR_CFG,
        WR_TRIG,
        DONE
    } csr_state_t;

    localparam logic [2:0] DEF_TRIG_ADDR   = 3'd0;
    localparam logic [2:0] DEF_CONFIG_ADDR = 3'd1;
    localparam logic [2:0] DEF_STATUS_ADDR = 3'd2;

    localparam logic [7:0] CMD_RDSR = 8'h52;
    localparam logic [7:0] CMD_RDCR = 8'h45;
    localparam logic [7:0] CMD_WRCR = 8'h47;

    localparam logic [31:0] TRIG_WORD = 32'h0000_0001;

    // Bit0 is the overwrite flag and bit1 is config_sel; everything else must be zero.
    function automatic logic [31:0] cfg_word(input logic [1:0] sel);
        return {30'b0, sel};
    endfunction

endpackage

// File: rtl/dual_config_csr_responder_read_port.sv
// csr_avmm_read_port: issues one Avalon-MM read and waits a fixed latency for the data.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   issue           one-cycle request; the read strobe is driven in the same cycle
//   issue_addr      IP CSR offset for this read
//   avmm_read       read strobe toward the IP
//   read_address    address toward the IP, zero when no read is being issued
//   avmm_readdata   IP read data, valid READ_LATENCY cycles after the strobe
//   rvalid          one-cycle pulse in the cycle rdata holds the answer
//   rdata           read data passed back to the caller
module csr_avmm_read_port #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue,
    input  logic [2:0]  issue_addr,
    output logic        avmm_read,
    output logic [2:0]  read_address,
    input  logic [31:0] avmm_readdata,
    output logic        rvalid,
    output logic [31:0] rdata
);

    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam logic [LW-1:0] LAT_LOAD = LW'(READ_LATENCY);
    localparam logic [LW-1:0] LAT_LAST = LW'(1);

    logic [LW-1:0] lat_cnt;

    // The counter is loaded at the edge that ends the strobe cycle and then counts down,
    // so it reads 1 exactly in the cycle the IP presents valid data.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (issue) begin
            lat_cnt <= LAT_LOAD;
        end else if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_LAST;
        end
    end

    assign avmm_read    = issue;
    assign read_address = issue ? issue_addr : 3'd0;
    assign rvalid       = (lat_cnt == LAT_LAST);
    assign rdata        = avmm_readdata;

endmodule

// File: rtl/dual_config_csr_responder.sv
// dual_config_csr_responder: turns StateMachine CSR requests (RDSR, RDCR, WRCR) into
// Avalon-MM transactions on the MAX10 dual-configuration IP CSR port.
// Ports:
//   clk, reset                       system clock, synchronous active-high reset
//   start_rdsr/start_rdcr/start_wrcr one-cycle requests, sampled only while idle
//   wr_data_csr                      WRCR payload: [1:0] config word, [31] trigger reconfig
//   rd_data_csr                      last captured RDSR/RDCR data, held until the next read
//   done_csr                         one-cycle completion pulse for every accepted request
//   err_timeout                      pulses with done_csr when the WRCR busy poll gives up
//   avmm_address/read/write/
//   writedata/readdata               Avalon-MM master toward the IP CSR slave
module dual_config_csr_responder
    import csr_pkg::*;
#(
    parameter int         READ_LATENCY = 2,
    parameter logic [2:0] STATUS_ADDR  = DEF_STATUS_ADDR,
    parameter logic [2:0] CONFIG_ADDR  = DEF_CONFIG_ADDR,
    parameter logic [2:0] TRIG_ADDR    = DEF_TRIG_ADDR,
    parameter int         POLL_MAX     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_rdsr,
    input  logic        start_rdcr,
    input  logic        start_wrcr,
    input  logic [31:0] wr_data_csr,
    output logic [31:0] rd_data_csr,
    output logic        done_csr,
    output logic        err_timeout,
    output logic [2:0]  avmm_address,
    output logic        avmm_read,
    output logic        avmm_write,
    output logic [31:0] avmm_writedata,
    input  logic [31:0] avmm_readdata
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);
    localparam logic [PW-1:0] POLL_ONE   = PW'(1);

    csr_state_t    state;
    csr_state_t    state_next;

    logic [2:0]    rd_addr;
    logic [1:0]    wr_cfg_sel;
    logic          wr_trigger;
    logic [PW-1:0] poll_cnt;
    logic          timed_out;

    logic          rd_issue;
    logic [2:0]    rd_issue_addr;
    logic [2:0]    rd_port_address;
    logic          rvalid;
    logic [31:0]   rdata;
    logic [2:0]    wr_address;

    csr_avmm_read_port #(
        .READ_LATENCY (READ_LATENCY)
    ) u_read_port (
        .clk           (clk),
        .reset         (reset),
        .issue         (rd_issue),
        .issue_addr    (rd_issue_addr),
        .avmm_read     (avmm_read),
        .read_address  (rd_port_address),
        .avmm_readdata (avmm_readdata),
        .rvalid        (rvalid),
        .rdata         (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request context and counters. The read address and WRCR payload are latched on the
    // accepting cycle so later changes on the inputs cannot disturb a transaction in flight.
    // The poll counter counts issued polls; it stops at POLL_MAX because the FSM leaves the
    // poll loop there, and the guard keeps it from ever wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr     <= 3'd0;
            wr_cfg_sel  <= 2'd0;
            wr_trigger  <= 1'b0;
            poll_cnt    <= '0;
            timed_out   <= 1'b0;
            rd_data_csr <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    poll_cnt  <= '0;
                    timed_out <= 1'b0;
                    if (start_rdsr) begin
                        rd_addr <= STATUS_ADDR;
                    end else if (start_rdcr) begin
                        rd_addr <= CONFIG_ADDR;
                    end else if (start_wrcr) begin
                        wr_cfg_sel <= wr_data_csr[1:0];
                        wr_trigger <= wr_data_csr[31];
                    end
                end
                RD_WAIT: begin
                    if (rvalid) begin
                        rd_data_csr <= rdata;
                    end
                end
                POLL_ISSUE: begin
                    if (poll_cnt != POLL_LIMIT) begin
                        poll_cnt <= poll_cnt + POLL_ONE;
                    end
                end
                POLL_WAIT: begin
                    if (rvalid && rdata[0] && (poll_cnt == POLL_LIMIT)) begin
                        timed_out <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and Moore outputs. Read strobes come only from RD_ISSUE/POLL_ISSUE and
    // write strobes only from WR_CFG/WR_TRIG, so the two strobes can never overlap.
    always_comb begin
        state_next     = state;
        rd_issue       = 1'b0;
        rd_issue_addr  = 3'd0;
        avmm_write     = 1'b0;
        wr_address     = 3'd0;
        avmm_writedata = 32'd0;
        done_csr       = 1'b0;
        err_timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (start_rdsr || start_rdcr) begin
                    state_next = RD_ISSUE;
                end else if (start_wrcr) begin
                    state_next = POLL_ISSUE;
                end
            end
            RD_ISSUE: begin
                rd_issue      = 1'b1;
                rd_issue_addr = rd_addr;
                state_next    = RD_WAIT;
            end
            RD_WAIT: begin
                if (rvalid) begin
                    state_next = DONE;
                end
            end
            POLL_ISSUE: begin
                rd_issue      = 1'b1;
                rd_issue_addr = STATUS_ADDR;
                state_next    = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (rvalid) begin
                    if (!rdata[0]) begin
                        state_next = WR_CFG;
                    end else if (poll_cnt == POLL_LIMIT) begin
                        state_next = DONE;
                    end else begin
                        state_next = POLL_ISSUE;
                    end
                end
            end
            WR_CFG: begin
                avmm_write     = 1'b1;
                wr_address     = CONFIG_ADDR;
                avmm_writedata = cfg_word(wr_cfg_sel);
                state_next     = wr_trigger ? WR_TRIG : DONE;
            end
            WR_TRIG: begin
                avmm_write     = 1'b1;
                wr_address     = TRIG_ADDR;
                avmm_writedata = TRIG_WORD;
                state_next     = DONE;
            end
            DONE: begin
                done_csr    = 1'b1;
                err_timeout = timed_out;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Both address sources are zero when their strobe is inactive, so OR-ing them merges
    // the read and write paths and leaves the bus at zero between strobes.
    assign avmm_address = rd_port_address | wr_address;

endmodule

// File: tb/tb_dual_config_csr_responder.sv
// Testbench for dual_config_csr_responder. The dual-config IP is modelled as a register file
// with a two-cycle read pipeline and a scripted busy bit. Each request's expected bus
// transactions, completion time, error flag and read data are derived from the request
// rules, then compared against the transactions the monitor logs from the bus.
module tb_dual_config_csr_responder;

    localparam int LAT  = 2;
    localparam int PMAX = 4;
    localparam logic [2:0] A_TRIG = 3'd0;
    localparam logic [2:0] A_CFG  = 3'd1;
    localparam logic [2:0] A_STAT = 3'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_rdsr, start_rdcr, start_wrcr;
    logic [31:0] wr_data_csr;
    logic [31:0] rd_data_csr;
    logic        done_csr, err_timeout;
    logic [2:0]  avmm_address;
    logic        avmm_read, avmm_write;
    logic [31:0] avmm_writedata, avmm_readdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] regs [0:7];
    bit          busy_script [$];
    bit          busy_stuck;
    logic [31:0] pipe0, pipe1;
    logic [63:0] txn_log [$];
    logic [63:0] txn_exp [$];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    dual_config_csr_responder #(
        .READ_LATENCY (LAT),
        .STATUS_ADDR  (A_STAT),
        .CONFIG_ADDR  (A_CFG),
        .TRIG_ADDR    (A_TRIG),
        .POLL_MAX     (PMAX)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_rdsr     (start_rdsr),
        .start_rdcr     (start_rdcr),
        .start_wrcr     (start_wrcr),
        .wr_data_csr    (wr_data_csr),
        .rd_data_csr    (rd_data_csr),
        .done_csr       (done_csr),
        .err_timeout    (err_timeout),
        .avmm_address   (avmm_address),
        .avmm_read      (avmm_read),
        .avmm_write     (avmm_write),
        .avmm_writedata (avmm_writedata),
        .avmm_readdata  (avmm_readdata)
    );

    // One logged bus transaction: kind (0 read, 1 write), address, data, cycle number.
    function automatic logic [63:0] mk(input bit w, input logic [2:0] a, input logic [31:0] d, input int c);
        logic [15:0] c16;
        c16 = c[15:0];
        return {w, 12'd0, a, d, c16};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // IP model: reads are answered two cycles after the strobe; status bit0 comes from the
    // busy script. Junk is returned outside valid slots so mistimed captures show up.
    always @(posedge clk) begin : ip_model
        logic [31:0] v;
        bit b;
        if (avmm_read) begin
            v = regs[avmm_address];
            if (avmm_address == A_STAT) begin
                if (busy_stuck) b = 1'b1;
                else if (busy_script.size() > 0) b = busy_script.pop_front();
                else b = 1'b0;
                v[0] = b;
            end
        end else begin
            v = $urandom;
        end
        pipe0 <= v;
        pipe1 <= pipe0;
    end
    assign avmm_readdata = pipe1;

    // Bus monitor: logs every strobe and checks bus hygiene every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (avmm_read)  txn_log.push_back(mk(1'b0, avmm_address, 32'd0, cyc));
            if (avmm_write) txn_log.push_back(mk(1'b1, avmm_address, avmm_writedata, cyc));
            checkOutput("rd_wr_overlap", {63'd0, avmm_read & avmm_write}, 64'd0);
            checkOutput("err_without_done", {63'd0, err_timeout & ~done_csr}, 64'd0);
            if (!avmm_read && !avmm_write)
                checkOutput("idle_bus", {29'd0, avmm_address, avmm_writedata}, 64'd0);
        end
    end

    // Runs one request. starts: bit0 rdsr, bit1 rdcr, bit2 wrcr. busy_polls: number of
    // status polls that report busy before going idle; stuck: busy never clears;
    // noise: fire all starts again while the request is in flight.
    task automatic applyStimulus(input logic [2:0] starts, input logic [31:0] wdata,
                                 input int busy_polls, input bit stuck, input bit noise);
        int s, exp_lat, polls, t, done_cyc;
        bit exp_err, got_done, done_err, timeout;
        logic [31:0] v;
        txn_exp.delete();
        busy_script.delete();
        busy_stuck = stuck;
        for (int i = 0; i < busy_polls; i++) busy_script.push_back(1'b1);
        @(negedge clk);
        txn_log.delete();
        s = cyc;
        start_rdsr  = starts[0];
        start_rdcr  = starts[1];
        start_wrcr  = starts[2];
        wr_data_csr = wdata;
        exp_err = 1'b0;
        if (starts[0] || starts[1]) begin
            txn_exp.push_back(mk(1'b0, starts[0] ? A_STAT : A_CFG, 32'd0, s + 1));
            exp_lat = 2 + LAT;
            if (starts[0]) begin
                v = regs[A_STAT];
                v[0] = stuck || (busy_polls > 0);
            end else begin
                v = regs[A_CFG];
            end
            last_rd = v;
        end else begin
            timeout = stuck || (busy_polls >= PMAX);
            polls = timeout ? PMAX : busy_polls + 1;
            for (int p = 0; p < polls; p++)
                txn_exp.push_back(mk(1'b0, A_STAT, 32'd0, s + 1 + p * (1 + LAT)));
            t = s + polls * (1 + LAT);
            if (timeout) begin
                exp_err = 1'b1;
                exp_lat = t + 1 - s;
            end else begin
                txn_exp.push_back(mk(1'b1, A_CFG, {30'd0, wdata[1:0]}, t + 1));
                if (wdata[31]) txn_exp.push_back(mk(1'b1, A_TRIG, 32'd1, t + 2));
                exp_lat = t + 2 + int'(wdata[31]) - s;
            end
        end
        got_done = 1'b0;
        done_cyc = 0;
        done_err = 1'b0;
        for (int c = 1; c <= 60 && !got_done; c++) begin
            @(negedge clk);
            start_rdsr  = 1'b0;
            start_rdcr  = 1'b0;
            start_wrcr  = 1'b0;
            wr_data_csr = $urandom;
            if (c == 1 && noise) begin
                start_rdsr = 1'b1;
                start_rdcr = 1'b1;
                start_wrcr = 1'b1;
            end
            if (done_csr) begin
                got_done = 1'b1;
                done_cyc = cyc;
                done_err = err_timeout;
            end
        end
        checkOutput("done_seen", {63'd0, got_done}, 64'd1);
        if (got_done) begin
            checkOutput("done_latency", 64'(done_cyc - s), 64'(exp_lat));
            checkOutput("err_timeout", {63'd0, done_err}, {63'd0, exp_err});
            @(negedge clk);
            checkOutput("done_width", {63'd0, done_csr}, 64'd0);
        end else begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            last_rd = 32'd0;
        end
        repeat (3) @(negedge clk);
        checkOutput("txn_count", 64'(txn_log.size()), 64'(txn_exp.size()));
        for (int i = 0; i < txn_exp.size() && i < txn_log.size(); i++)
            checkOutput("txn", txn_log[i], txn_exp[i]);
        checkOutput("rd_data_csr", {32'd0, rd_data_csr}, {32'd0, last_rd});
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        int s;
        for (int i = 0; i < 8; i++) regs[i] = $urandom;
        busy_stuck  = 1'b0;
        last_rd     = 32'd0;
        reset       = 1'b1;
        start_rdsr  = 1'b0;
        start_rdcr  = 1'b0;
        start_wrcr  = 1'b0;
        wr_data_csr = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {57'd0, done_csr, err_timeout, avmm_read, avmm_write, avmm_address}, 64'd0);
        checkOutput("reset_data", {avmm_writedata, rd_data_csr}, 64'd0);
        reset = 1'b0;

        // Directed scenarios.
        regs[A_STAT] = 32'hA5C3_0000;
        applyStimulus(3'b001, 32'd0, 0, 1'b0, 1'b0);
        regs[A_CFG] = 32'h0000_0003;
        applyStimulus(3'b010, 32'd0, 0, 1'b0, 1'b0);
        applyStimulus(3'b100, 32'h8000_0002, 0, 1'b0, 1'b0);
        applyStimulus(3'b100, 32'h0000_0001, 3, 1'b0, 1'b0);
        applyStimulus(3'b100, 32'h8000_0003, 0, 1'b1, 1'b0);
        applyStimulus(3'b101, 32'h8000_0001, 0, 1'b0, 1'b0);
        applyStimulus(3'b110, 32'h8000_0001, 0, 1'b0, 1'b1);

        // Reset during RD_WAIT: bus and outputs drop at once and no completion follows.
        @(negedge clk);
        txn_log.delete();
        s = cyc;
        start_rdsr = 1'b1;
        @(negedge clk);
        start_rdsr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_rd = 32'd0;
        checkOutput("rst_mid_ctrl", {57'd0, done_csr, err_timeout, avmm_read, avmm_write, avmm_address}, 64'd0);
        checkOutput("rst_mid_data", {avmm_writedata, rd_data_csr}, 64'd0);
        repeat (6) begin
            @(negedge clk);
            checkOutput("rst_quiet", {61'd0, done_csr, avmm_read, avmm_write}, 64'd0);
        end
        checkOutput("rst_txn_count", 64'(txn_log.size()), 64'd1);
        if (txn_log.size() > 0)
            checkOutput("rst_txn", txn_log[0], mk(1'b0, A_STAT, 32'd0, s + 1));

        // Randomized requests against the reference model.
        for (int n = 0; n < 30; n++) begin
            regs[A_STAT] = $urandom;
            regs[A_CFG]  = $urandom;
            applyStimulus(3'($urandom_range(1, 7)), $urandom, $urandom_range(0, 5),
                          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
